// File: rtl/cypher_rr_arbiter_if.sv
// Handshake bundle between the four cypher requesters, the round-robin arbiter
// and the downstream consumer. The master side is the requester/consumer environment.
interface cypher_rr_arbiter_if #(
  parameter int WIDTH = 4
);
  logic [3:0]       req;
  logic [WIDTH-1:0] cypher0;
  logic [WIDTH-1:0] cypher1;
  logic [WIDTH-1:0] cypher2;
  logic [WIDTH-1:0] cypher3;
  logic [3:0]       ack;
  logic [1:0]       sel;
  logic [WIDTH-1:0] cypher;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  modport master (
    output req, cypher0, cypher1, cypher2, cypher3, out_ready,
    input  ack, sel, cypher, out_valid, busy
  );

  modport slave (
    input  req, cypher0, cypher1, cypher2, cypher3, out_ready,
    output ack, sel, cypher, out_valid, busy
  );
endinterface

// File: rtl/cypher_rr_arbiter.sv
// Round-robin arbiter sharing the 4-way cypher mux: grants one requester at a time,
// registers its beat and holds it on a valid/ready output until the consumer accepts.
module cypher_rr_arbiter #(
  parameter int WIDTH = 4,
  parameter int BURST = 1
) (
  input logic              clk,
  input logic              rst_n,
  cypher_rr_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [4:0] BURST_W = 5'(BURST);

  // First set bit of r scanning base, base+1, ... modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = base;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = base + 2'(i);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [3:0]       beat_cnt_q, beat_cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] cypher_q, cypher_d;
  logic             out_valid_q, out_valid_d;
  logic [3:0]       ack_q, ack_d;
  logic             busy_q, busy_d;

  logic [1:0]       arb_base_s;
  logic [1:0]       winner_s;
  logic [WIDTH-1:0] cypher_win_s;
  logic [WIDTH-1:0] cypher_cur_s;
  logic             burst_more_s;

  // In SEND the pointer update and re-arbitration share one edge, so arbitrate from sel+1.
  assign arb_base_s   = (state_q == SEND) ? (sel_q + 2'd1) : ptr_q;
  assign winner_s     = rr_pick(bus.req, arb_base_s);
  assign burst_more_s = (({1'b0, beat_cnt_q} + 5'd1) < BURST_W) && bus.req[sel_q];

  // Beat mux for the freshly arbitrated winner.
  always_comb begin
    cypher_win_s = '0;
    case (winner_s)
      2'd0:    cypher_win_s = bus.cypher0;
      2'd1:    cypher_win_s = bus.cypher1;
      2'd2:    cypher_win_s = bus.cypher2;
      2'd3:    cypher_win_s = bus.cypher3;
      default: cypher_win_s = '0;
    endcase
  end

  // Beat mux for the current holder, used when a burst continues.
  always_comb begin
    cypher_cur_s = '0;
    case (sel_q)
      2'd0:    cypher_cur_s = bus.cypher0;
      2'd1:    cypher_cur_s = bus.cypher1;
      2'd2:    cypher_cur_s = bus.cypher2;
      2'd3:    cypher_cur_s = bus.cypher3;
      default: cypher_cur_s = '0;
    endcase
  end

  // Next-state and capture decisions.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    beat_cnt_d  = beat_cnt_q;
    sel_d       = sel_q;
    cypher_d    = cypher_q;
    out_valid_d = out_valid_q;
    ack_d       = 4'b0000;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          sel_d       = winner_s;
          cypher_d    = cypher_win_s;
          ack_d       = onehot4(winner_s);
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
          state_d     = SEND;
        end else begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      end
      SEND: begin
        if (bus.out_ready) begin
          if (burst_more_s) begin
            beat_cnt_d = beat_cnt_q + 4'd1;
            cypher_d   = cypher_cur_s;
            ack_d      = onehot4(sel_q);
          end else begin
            ptr_d      = sel_q + 2'd1;
            beat_cnt_d = 4'd0;
            if (|bus.req) begin
              sel_d    = winner_s;
              cypher_d = cypher_win_s;
              ack_d    = onehot4(winner_s);
            end else begin
              out_valid_d = 1'b0;
              busy_d      = 1'b0;
              state_d     = IDLE;
            end
          end
        end else begin
          state_d = SEND;
        end
      end
      default: begin
        state_d     = IDLE;
        ptr_d       = 2'd0;
        beat_cnt_d  = 4'd0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      beat_cnt_q  <= 4'd0;
      sel_q       <= 2'd0;
      cypher_q    <= '0;
      out_valid_q <= 1'b0;
      ack_q       <= 4'b0000;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      sel_q       <= sel_d;
      cypher_q    <= cypher_d;
      out_valid_q <= out_valid_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.cypher    = cypher_q;
  assign bus.out_valid = out_valid_q;
  assign bus.ack       = ack_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_cypher_rr_arbiter.sv
// Scoreboard bench for cypher_rr_arbiter: two instances (BURST=1 and BURST=2) share
// the same stimulus; each scenario queues expected outputs and pops them edge by edge.
module tb_cypher_rr_arbiter;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] cy;
    logic [3:0] ack;
    logic       v;
    logic       b;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req_s = 4'b0000;
  logic       rdy_s = 1'b0;
  logic [3:0] cy0_s = 4'h0, cy1_s = 4'h0, cy2_s = 4'h0, cy3_s = 4'h0;
  logic       use_b2 = 1'b0;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  cypher_rr_arbiter_if #(.WIDTH(4)) b1 ();
  cypher_rr_arbiter_if #(.WIDTH(4)) b2 ();

  assign b1.req = req_s;  assign b1.out_ready = rdy_s;
  assign b1.cypher0 = cy0_s; assign b1.cypher1 = cy1_s;
  assign b1.cypher2 = cy2_s; assign b1.cypher3 = cy3_s;
  assign b2.req = req_s;  assign b2.out_ready = rdy_s;
  assign b2.cypher0 = cy0_s; assign b2.cypher1 = cy1_s;
  assign b2.cypher2 = cy2_s; assign b2.cypher3 = cy3_s;

  cypher_rr_arbiter #(.WIDTH(4), .BURST(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  cypher_rr_arbiter #(.WIDTH(4), .BURST(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

  function automatic exp_t sample();
    exp_t g;
    if (use_b2) g = '{sel: b2.sel, cy: b2.cypher, ack: b2.ack, v: b2.out_valid, b: b2.busy};
    else        g = '{sel: b1.sel, cy: b1.cypher, ack: b1.ack, v: b1.out_valid, b: b1.busy};
    return g;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; req_s = 4'b0000; rdy_s = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    exp_t e, g;
    // Power-on reset values, checked before any clock edge.
    rst_n = 1'b0; #1;
    sb_q.push_back('{sel: 2'd0, cy: 4'h0, ack: 4'b0000, v: 1'b0, b: 1'b0});
    e = sb_q.pop_front(); g = sample(); vectors++;
    if (g !== e) begin miscompares++; $display("FAIL reset_init got %h want %h", g, e); end
    do_reset();
    cy0_s = 4'h5; req_s = 4'b0001; rdy_s = 1'b0;
    sb_q.push_back('{sel: 2'd0, cy: 4'h5, ack: 4'b0001, v: 1'b1, b: 1'b1});
    sb_q.push_back('{sel: 2'd0, cy: 4'h0, ack: 4'b0000, v: 1'b0, b: 1'b0});
    sb_q.push_back('{sel: 2'd0, cy: 4'h0, ack: 4'b0000, v: 1'b0, b: 1'b0});
    @(posedge clk); #1;
    e = sb_q.pop_front(); g = sample(); vectors++;
    if (g !== e) begin miscompares++; $display("FAIL reset_presend got %h want %h", g, e); end
    // Async reset mid-cycle, away from any clock edge.
    #2; rst_n = 1'b0; #1;
    e = sb_q.pop_front(); g = sample(); vectors++;
    if (g !== e) begin miscompares++; $display("FAIL reset_async got %h want %h", g, e); end
    req_s = 4'b0000; #1; rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    e = sb_q.pop_front(); g = sample(); vectors++;
    if (g !== e) begin miscompares++; $display("FAIL reset_idle got %h want %h", g, e); end
  endtask

  task automatic run_steps(input string name, input logic [3:0] rq[], input logic rd[]);
    exp_t e, g;
    for (int i = 0; i < rq.size(); i++) begin
      req_s = rq[i]; rdy_s = rd[i];
      @(posedge clk); #1;
      if (sb_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL %s step %0d: scoreboard empty", name, i);
      end else begin
        e = sb_q.pop_front(); g = sample(); vectors++;
        if (g !== e) begin
          miscompares++;
          $display("FAIL %s step %0d: got sel=%0d cy=%h ack=%b v=%b busy=%b want sel=%0d cy=%h ack=%b v=%b busy=%b",
                   name, i, g.sel, g.cy, g.ack, g.v, g.b, e.sel, e.cy, e.ack, e.v, e.b);
        end
      end
    end
  endtask

  task automatic test_single();
    do_reset(); use_b2 = 1'b0;
    cy2_s = 4'hA;
    sb_q.push_back('{sel: 2'd2, cy: 4'hA, ack: 4'b0100, v: 1'b1, b: 1'b1});
    sb_q.push_back('{sel: 2'd2, cy: 4'hA, ack: 4'b0000, v: 1'b0, b: 1'b0});
    run_steps("single", '{4'b0100, 4'b0000}, '{1'b1, 1'b1});
  endtask

  task automatic test_round_robin();
    do_reset(); use_b2 = 1'b0;
    cy0_s = 4'h5; cy1_s = 4'h6; cy2_s = 4'h9; cy3_s = 4'hC;
    sb_q.push_back('{sel: 2'd0, cy: 4'h5, ack: 4'b0001, v: 1'b1, b: 1'b1});
    sb_q.push_back('{sel: 2'd1, cy: 4'h6, ack: 4'b0010, v: 1'b1, b: 1'b1});
    sb_q.push_back('{sel: 2'd2, cy: 4'h9, ack: 4'b0100, v: 1'b1, b: 1'b1});
    sb_q.push_back('{sel: 2'd3, cy: 4'hC, ack: 4'b1000, v: 1'b1, b: 1'b1});
    sb_q.push_back('{sel: 2'd0, cy: 4'h5, ack: 4'b0001, v: 1'b1, b: 1'b1});
    sb_q.push_back('{sel: 2'd0, cy: 4'h5, ack: 4'b0000, v: 1'b0, b: 1'b0});
    run_steps("round_robin", '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0},
              '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1});
  endtask

  task automatic test_backpressure();
    exp_t e, g;
    do_reset(); use_b2 = 1'b0;
    cy0_s = 4'h3; cy1_s = 4'h7; cy2_s = 4'hE;
    sb_q.push_back('{sel: 2'd1, cy: 4'h7, ack: 4'b0010, v: 1'b1, b: 1'b1});
    run_steps("bp_capture", '{4'b0010}, '{1'b0});
    // Source changes and new requests must not disturb the held beat.
    cy1_s = 4'h8;
    repeat (3) sb_q.push_back('{sel: 2'd1, cy: 4'h7, ack: 4'b0000, v: 1'b1, b: 1'b1});
    sb_q.push_back('{sel: 2'd2, cy: 4'hE, ack: 4'b0100, v: 1'b1, b: 1'b1});
    sb_q.push_back('{sel: 2'd0, cy: 4'h3, ack: 4'b0001, v: 1'b1, b: 1'b1});
    sb_q.push_back('{sel: 2'd0, cy: 4'h3, ack: 4'b0000, v: 1'b0, b: 1'b0});
    run_steps("backpressure", '{4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0001, 4'b0000},
              '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1});
    // out_ready while idle is ignored.
    sb_q.push_back('{sel: 2'd0, cy: 4'h3, ack: 4'b0000, v: 1'b0, b: 1'b0});
    req_s = 4'b0000; rdy_s = 1'b1;
    @(posedge clk); #1;
    e = sb_q.pop_front(); g = sample(); vectors++;
    if (g !== e) begin miscompares++; $display("FAIL idle_ready got %h want %h", g, e); end
  endtask

  task automatic test_burst2();
    do_reset(); use_b2 = 1'b1;
    cy0_s = 4'h5; cy1_s = 4'h6;
    sb_q.push_back('{sel: 2'd0, cy: 4'h5, ack: 4'b0001, v: 1'b1, b: 1'b1});
    sb_q.push_back('{sel: 2'd0, cy: 4'h5, ack: 4'b0001, v: 1'b1, b: 1'b1});
    sb_q.push_back('{sel: 2'd1, cy: 4'h6, ack: 4'b0010, v: 1'b1, b: 1'b1});
    sb_q.push_back('{sel: 2'd1, cy: 4'h6, ack: 4'b0010, v: 1'b1, b: 1'b1});
    sb_q.push_back('{sel: 2'd0, cy: 4'h5, ack: 4'b0001, v: 1'b1, b: 1'b1});
    sb_q.push_back('{sel: 2'd0, cy: 4'h5, ack: 4'b0001, v: 1'b1, b: 1'b1});
    sb_q.push_back('{sel: 2'd0, cy: 4'h5, ack: 4'b0000, v: 1'b0, b: 1'b0});
    run_steps("burst2", '{4'h3, 4'h3, 4'h3, 4'h3, 4'h3, 4'h3, 4'h0},
              '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1});
    use_b2 = 1'b0;
  endtask

  task automatic test_fairness();
    do_reset(); use_b2 = 1'b0;
    cy0_s = 4'h5; cy3_s = 4'hC;
    sb_q.push_back('{sel: 2'd3, cy: 4'hC, ack: 4'b1000, v: 1'b1, b: 1'b1});
    sb_q.push_back('{sel: 2'd0, cy: 4'h5, ack: 4'b0001, v: 1'b1, b: 1'b1});
    sb_q.push_back('{sel: 2'd3, cy: 4'hC, ack: 4'b1000, v: 1'b1, b: 1'b1});
    sb_q.push_back('{sel: 2'd3, cy: 4'hC, ack: 4'b1000, v: 1'b1, b: 1'b1});
    sb_q.push_back('{sel: 2'd3, cy: 4'hC, ack: 4'b0000, v: 1'b0, b: 1'b0});
    run_steps("fairness", '{4'b1000, 4'b1001, 4'b1001, 4'b1000, 4'b0000},
              '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_burst2();
    test_fairness();
    if (sb_q.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL scoreboard_leftover got %0d want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
